// File: rtl/mult_pkg.sv
// mult_pkg
//   Shared definitions for the multiplier result accumulator.
//   - default widths for product, accumulator and batch counter
//   - accumulator FSM state encoding
//   - signed-add overflow helper used by the accumulator datapath
package mult_pkg;

  localparam int PROD_W_DEF = 16;
  localparam int ACC_W_DEF  = 24;
  localparam int CNT_W_DEF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Two's complement overflow: both addends share a sign and the sum does not.
  function automatic logic add_ovf(input logic a_sign, input logic b_sign,
                                   input logic s_sign);
    return (a_sign == b_sign) && (s_sign != a_sign);
  endfunction

endpackage

// File: rtl/mult_done_detect.sv
// mult_done_detect
//   Turns the multiplier busy flag into a one-cycle completion strobe.
//   The strobe is combinational (registered busy high, live busy low), so the
//   consumer acts on the same rising edge that first samples busy low.
//   Clearing the register on reset means a busy level seen before reset is
//   forgotten: a completion needs busy sampled high after reset first.
// Ports
//   i_clk   in  clock, rising edge
//   i_rst   in  synchronous active-high clear of the busy history
//   i_busy  in  multiplier busy flag
//   o_cmpl  out completion strobe (busy falling)
module mult_done_detect (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_busy,
  output logic o_cmpl
);

  logic r_busy_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_busy_d <= 1'b0;
    else       r_busy_d <= i_busy;
  end

  assign o_cmpl = r_busy_d & ~i_busy;

endmodule

// File: rtl/mult_result_accum.sv
// mult_result_accum
//   Accumulates signed products from the sequential multiplier into a wide
//   signed sum, counting products until the programmed batch size is reached,
//   then holds the final sum with acc_valid high until clear or reset.
//
//   Interface contract: y is only meaningful on the cycle busy is first sampled
//   low after being high; that busy fall is the single "valid" event, and there
//   is no ready/backpressure -- a completion arriving while the batch is DONE is
//   discarded and flagged on the sticky drop output.
//
// Configuration
//   MULT_ACC_SAT_EN  defined: overflowing sums clamp to the signed extreme in
//                    the direction of the addend; ovf is still set.
//                    undefined: sums wrap modulo 2^ACC_W; ovf only.
// Ports
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high, clears all state
//   clear      in   synchronous batch restart, same effect as reset
//   batch_len  in   products per batch (0 treated as 1), sampled per completion
//   y          in   signed product, valid when busy falls
//   busy       in   multiplier busy flag
//   acc        out  signed running sum
//   acc_valid  out  batch sum final (state DONE)
//   prod_cnt   out  products accumulated in the current batch
//   ovf        out  sticky signed overflow
//   drop       out  sticky completion-discarded-in-DONE
//   dbg_state  out  current FSM state
module mult_result_accum
  import mult_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [CNT_W-1:0]  batch_len,
  input  logic [PROD_W-1:0] y,
  input  logic              busy,
  output logic [ACC_W-1:0]  acc,
  output logic              acc_valid,
  output logic [CNT_W-1:0]  prod_cnt,
  output logic              ovf,
  output logic              drop,
  output state_t            dbg_state
);

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t           r_state, w_state_nxt;
  logic [ACC_W-1:0] r_acc, w_acc_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic             r_drop, w_drop_nxt;

  logic             w_rst_any;
  logic             w_cmpl;
  logic [ACC_W-1:0] w_addend;
  logic [ACC_W-1:0] w_base;
  logic [ACC_W-1:0] w_sum;
  logic             w_sum_ovf;
  // One extra bit so the increment and the length compare never wrap.
  logic [CNT_W:0]   w_cnt_inc;
  logic [CNT_W:0]   w_len_eff;

  // clear restarts the batch exactly like reset, including the busy history.
  assign w_rst_any = reset | clear;

  mult_done_detect u_done (
    .i_clk  (clk),
    .i_rst  (w_rst_any),
    .i_busy (busy),
    .o_cmpl (w_cmpl)
  );

  assign w_addend  = ACC_W'($signed(y));
  // The first product of a batch starts from zero rather than the old sum.
  assign w_base    = (r_state == ST_IDLE) ? '0 : r_acc;
  assign w_sum     = w_base + w_addend;
  assign w_sum_ovf = add_ovf(w_base[ACC_W-1], w_addend[ACC_W-1], w_sum[ACC_W-1]);
  assign w_cnt_inc = (r_state == ST_IDLE) ? (CNT_W+1)'(1)
                                          : {1'b0, r_cnt} + (CNT_W+1)'(1);
  assign w_len_eff = (batch_len == '0) ? (CNT_W+1)'(1) : {1'b0, batch_len};

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_ovf_nxt   = r_ovf;
    w_drop_nxt  = r_drop;
    case (r_state)
      ST_IDLE, ST_RUN: begin
        if (w_cmpl) begin
`ifdef MULT_ACC_SAT_EN
          if (w_sum_ovf) w_acc_nxt = w_addend[ACC_W-1] ? ACC_MIN : ACC_MAX;
          else           w_acc_nxt = w_sum;
`else
          w_acc_nxt = w_sum;
`endif
          w_cnt_nxt = w_cnt_inc[CNT_W-1:0];
          if (w_sum_ovf) w_ovf_nxt = 1'b1;
          w_state_nxt = (w_cnt_inc >= w_len_eff) ? ST_DONE : ST_RUN;
        end
      end
      ST_DONE: begin
        if (w_cmpl) w_drop_nxt = 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_rst_any) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ovf   <= w_ovf_nxt;
      r_drop  <= w_drop_nxt;
    end
  end

  assign acc       = r_acc;
  assign acc_valid = (r_state == ST_DONE);
  assign prod_cnt  = r_cnt;
  assign ovf       = r_ovf;
  assign drop      = r_drop;
  assign dbg_state = r_state;

endmodule
